spi_master_multi: RTL and testbench

//  Parametrised successor to the single-mode SPI master on the CPU keyboard/display path.

---
 rtl/spi_master_multi_pkg.sv | 18 +
 rtl/spi_master_multi_if.sv | 40 ++++
 rtl/spi_master_multi_clkgen.sv | 45 ++++
 rtl/spi_master_multi.sv | 175 +++++++++++++++++
 tb/tb_spi_master_multi.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_multi_pkg.sv
// Shared types and constants for the multi-mode SPI master.
//   spi_state_e : FSM state encoding IDLE/SETUP/SHIFT/HOLD
//   MODE0..3    : SPI mode constants, encoded as {cpol, cpha}
package spi_master_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_multi_if.sv
// CPU strobe / GPIO pad bundle of the SPI master.
//   slave  modport : seen by the SPI master block (takes CPU strobes, drives pads)
//   master modport : seen by the CPU side that issues load/unload
//   load, datain, cpol, cpha, clk_div, ss_sel, unload : CPU -> block
//   dataout, busy, rx_valid, overrun                  : block -> CPU
//   sclk, mosi, ssn / miso                            : pads out / pad in
interface spi_master_multi_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_SS = 1,
  parameter int unsigned DIV_W  = 8
);
  localparam int unsigned SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              load;
  logic [DATA_W-1:0] datain;
  logic              cpol;
  logic              cpha;
  logic [DIV_W-1:0]  clk_div;
  logic [SSW-1:0]    ss_sel;
  logic              unload;
  logic [DATA_W-1:0] dataout;
  logic              busy;
  logic              rx_valid;
  logic              overrun;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ssn;

  modport slave (
    input  load, datain, cpol, cpha, clk_div, ss_sel, unload, miso,
    output dataout, busy, rx_valid, overrun, sclk, mosi, ssn
  );

  modport master (
    output load, datain, cpol, cpha, clk_div, ss_sel, unload, miso,
    input  dataout, busy, rx_valid, overrun, sclk, mosi, ssn
  );

endinterface

// File: rtl/spi_master_multi_clkgen.sv
// SCLK half-period divider and SHIFT edge counter.
//   clock_in, reset : system clock, synchronous active-low reset
//   restart         : FSM changes state this cycle; divider and edge count restart
//   shift_en        : FSM is in SHIFT; edges are only counted there
//   clk_div         : half-period = clk_div+1 cycles
//   tick_c          : last cycle of the current half-period
//   lead_c/trail_c  : tick on an even (leading) / odd (trailing) SCLK edge
//   last_edge_c     : tick on the final edge 2*DATA_W-1
module spi_master_multi_clkgen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             restart,
  input  logic             shift_en,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick_c,
  output logic             lead_c,
  output logic             trail_c,
  output logic             last_edge_c
);
  localparam int unsigned EDGES = 2 * DATA_W;
  localparam int unsigned EW    = (EDGES > 1) ? $clog2(EDGES) : 1;

  logic [DIV_W-1:0] cnt_q;
  logic [EW-1:0]    edge_q;

  assign tick_c      = (cnt_q == clk_div);
  assign lead_c      = shift_en && tick_c && !edge_q[0];
  assign trail_c     = shift_en && tick_c &&  edge_q[0];
  assign last_edge_c = shift_en && tick_c && (edge_q == EW'(EDGES - 1));

  // Exact counter: returns to 0 on tick, so it never wraps past clk_div.
  always_ff @(posedge clock_in) begin
    if (!reset || restart) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q <= tick_c ? '0 : cnt_q + DIV_W'(1);
      if (lead_c || trail_c) edge_q <= edge_q + EW'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master with runtime mode/divider and NUM_SS slave selects.
//   clock_in, reset : system clock, synchronous active-low reset
//   bus (slave)     : CPU strobes load/unload with TX word and transfer config,
//                     RX word and status flags back, SPI pads sclk/mosi/miso/ssn
// All outputs are registered.
module spi_master_multi
  import spi_master_multi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_SS    = 1,
  parameter int unsigned DIV_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clock_in,
  input  logic                 reset,
  spi_master_multi_if.slave    bus
);
  localparam int unsigned SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NUM_SS-1:0] ssn_q, ssn_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d;
  logic              busy_q, busy_d, rxv_q, rxv_d, ovr_q, ovr_d;
  logic              tick_c, lead_c, trail_c, last_c, restart_c, sample_c;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // RX fills from the end that leaves the word in natural order.
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Out-of-range select leaves every line deasserted.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SSW-1:0] s);
    logic [NUM_SS-1:0] r;
    r = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (SSW'(i) == s) r[i] = 1'b0;
    end
    return r;
  endfunction

  spi_master_multi_clkgen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_clkgen (
    .clock_in    (clock_in),
    .reset       (reset),
    .restart     (restart_c),
    .shift_en    (state_q == ST_SHIFT),
    .clk_div     (div_q),
    .tick_c      (tick_c),
    .lead_c      (lead_c),
    .trail_c     (trail_c),
    .last_edge_c (last_c)
  );

  assign restart_c = (state_d != state_q);
  assign sample_c  = cpha_q ? trail_c : lead_c;

  // Next state and next register values.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    div_d   = div_q;
    ssn_d   = ssn_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    rxv_d   = rxv_q;
    ovr_d   = ovr_q;

    if (bus.unload) begin
      rxv_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol_q;
        if (bus.load) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          div_d   = bus.clk_div;
          sclk_d  = bus.cpol;
          ssn_d   = ss_decode(bus.ss_sel);
          rx_d    = '0;
          // cpha=0 puts the first bit out during SETUP; cpha=1 waits for edge 0.
          tx_d    = bus.cpha ? bus.datain : tx_shift(bus.datain);
          mosi_d  = bus.cpha ? 1'b0 : first_bit(bus.datain);
        end
      end
      ST_SETUP: begin
        if (tick_c) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_c) begin
          sclk_d = ~sclk_q;
          if (sample_c) begin
            rx_d = rx_shift(rx_q, bus.miso);
          end else begin
            mosi_d = first_bit(tx_q);
            tx_d   = tx_shift(tx_q);
          end
          if (last_c) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          ssn_d   = '1;
          busy_d  = 1'b0;
          dout_d  = rx_q;
          rxv_d   = 1'b1;
          // A coincident unload consumes the old word, so no overrun.
          ovr_d   = bus.unload ? 1'b0 : (ovr_q | rxv_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      div_q   <= '0;
      ssn_q   <= '1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      rxv_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      div_q   <= div_d;
      ssn_q   <= ssn_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      rxv_q   <= rxv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dataout  = dout_q;
  assign bus.busy     = busy_q;
  assign bus.rx_valid = rxv_q;
  assign bus.overrun  = ovr_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.ssn      = ssn_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: an MSB-first and an LSB-first instance share
// all CPU stimulus; miso is either looped back or driven from a serial pattern.
module tb_spi_master_multi;
  import spi_master_multi_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 3;
  localparam int unsigned DV = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          load, unload, cpol, cpha, use_lb, ext_miso;
  logic [DW-1:0] datain;
  logic [DV-1:0] clk_div;
  logic [1:0]    ss_sel;

  int checks   = 0;
  int failures = 0;
  logic exp_rxv, exp_ov;
  logic [NS-1:0] all_hi = '1;

  spi_master_multi_if #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(DV)) if_m ();
  spi_master_multi_if #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(DV)) if_l ();

  assign if_m.load = load;      assign if_l.load = load;
  assign if_m.datain = datain;  assign if_l.datain = datain;
  assign if_m.cpol = cpol;      assign if_l.cpol = cpol;
  assign if_m.cpha = cpha;      assign if_l.cpha = cpha;
  assign if_m.clk_div = clk_div; assign if_l.clk_div = clk_div;
  assign if_m.ss_sel = ss_sel;  assign if_l.ss_sel = ss_sel;
  assign if_m.unload = unload;  assign if_l.unload = unload;
  assign if_m.miso = use_lb ? if_m.mosi : ext_miso;
  assign if_l.miso = use_lb ? if_l.mosi : ext_miso;

  spi_master_multi #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(DV), .MSB_FIRST(1'b1)) u_m (
    .clock_in (clk),
    .reset    (reset),
    .bus      (if_m)
  );

  spi_master_multi #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(DV), .MSB_FIRST(1'b0)) u_l (
    .clock_in (clk),
    .reset    (reset),
    .bus      (if_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW); i++) r[i] = w[int'(DW) - 1 - i];
    return r;
  endfunction

  task automatic check_idle_after_reset(input string tag);
    check({tag, "_busy"}, 32'(if_m.busy), 32'(0));
    check({tag, "_rxv"},  32'(if_m.rx_valid), 32'(0));
    check({tag, "_ovr"},  32'(if_m.overrun), 32'(0));
    check({tag, "_sclk"}, 32'(if_m.sclk), 32'(0));
    check({tag, "_ssn_m"}, 32'(if_m.ssn), 32'(all_hi));
    check({tag, "_ssn_l"}, 32'(if_l.ssn), 32'(all_hi));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_after_reset("rst");
    check("rst_dout", 32'(if_m.dataout), 32'(0));
    check("rst_mosi", 32'(if_m.mosi), 32'(0));
    reset = 1'b1;
    exp_rxv = 1'b0;
    exp_ov  = 1'b0;
  endtask

  task automatic do_unload();
    @(posedge clk); #1;
    unload = 1'b1;
    @(posedge clk); #1;
    unload = 1'b0;
    exp_rxv = 1'b0;
    exp_ov  = 1'b0;
    check("unload_rxv", 32'(if_m.rx_valid), 32'(exp_rxv));
    check("unload_ovr", 32'(if_m.overrun), 32'(exp_ov));
  endtask

  // One transfer. Expected timing is derived from the tick arithmetic:
  // SETUP 1 tick + 2*DW SHIFT ticks + HOLD 1 tick, +1 for the load cycle.
  task automatic xfer(input logic [DW-1:0] d, input logic pol, input logic pha,
                      input logic [DV-1:0] div, input logic [1:0] sel,
                      input logic lb, input logic [DW-1:0] pat, input int abort_edge,
                      input bit reload, input bit unl_start, input bit unl_end);
    int lat = (2 * int'(DW) + 2) * (int'(div) + 1) + 1;
    int cyc = 0, done = 0, n_edges = 0, rises = 0, s_idx = 0;
    int ss_bad = 0, mosi_bad = 0, busy_w = 0, last_mchg = 0, last_samp = -1000;
    logic prev_busy, prev_sclk, prev_mosi;
    logic [NS-1:0] exp_ssn = (int'(sel) < int'(NS)) ? ~(NS'(1) << sel) : '1;
    logic [DW-1:0] exp_m, exp_l;

    @(posedge clk); #1;
    datain = d; cpol = pol; cpha = pha; clk_div = div; ss_sel = sel;
    use_lb = lb; ext_miso = pat[DW-1]; load = 1'b1; unload = unl_start;
    if (unl_start) begin
      exp_rxv = 1'b0;
      exp_ov  = 1'b0;
    end
    prev_busy = if_m.busy; prev_sclk = if_m.sclk; prev_mosi = if_m.mosi;

    while (done == 0 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        load = 1'b0; unload = 1'b0; datain = ~d;
      end
      if (reload && cyc == 4) load = 1'b1;
      if (reload && cyc == 5) load = 1'b0;
      if (unl_end && cyc == lat - 1) unload = 1'b1;
      if (unl_end && cyc == lat) unload = 1'b0;

      if (if_m.busy) begin
        busy_w++;
        if (if_m.ssn !== exp_ssn) ss_bad++;
        if (if_l.ssn !== exp_ssn) ss_bad++;
        if (prev_busy && (if_m.sclk !== prev_sclk)) begin
          if (if_m.sclk) rises++;
          if ((n_edges % 2) == int'(pha)) begin
            if (cyc - last_mchg < int'(div) + 1) mosi_bad++;
            last_samp = cyc;
            s_idx++;
            ext_miso = (s_idx < int'(DW)) ? pat[3'(int'(DW) - 1 - s_idx)] : 1'b0;
          end
          n_edges++;
          if (abort_edge >= 0 && n_edges == abort_edge + 1) begin
            reset = 1'b0;
            @(posedge clk); #1;
            check_idle_after_reset("abort");
            reset = 1'b1;
            exp_rxv = 1'b0;
            exp_ov  = 1'b0;
            return;
          end
        end
        if (if_m.mosi !== prev_mosi) begin
          if (cyc - last_samp < int'(div) + 1) mosi_bad++;
          last_mchg = cyc;
        end
      end else if (prev_busy) begin
        done = cyc;
      end
      prev_busy = if_m.busy; prev_sclk = if_m.sclk; prev_mosi = if_m.mosi;
    end

    exp_ov  = unl_end ? 1'b0 : (exp_ov | exp_rxv);
    exp_rxv = 1'b1;
    exp_m   = lb ? d : pat;
    exp_l   = lb ? d : bitrev(pat);

    check("latency",     32'(done), 32'(lat));
    check("busy_width",  32'(busy_w), 32'(lat - 1));
    check("rx_valid",    32'(if_m.rx_valid), 32'(exp_rxv));
    check("overrun",     32'(if_m.overrun), 32'(exp_ov));
    check("dout_msb",    32'(if_m.dataout), 32'(exp_m));
    check("dout_lsb",    32'(if_l.dataout), 32'(exp_l));
    check("ssn_during",  32'(ss_bad), 32'(0));
    check("mosi_stable", 32'(mosi_bad), 32'(0));
    check("sclk_edges",  32'(n_edges), 32'(2 * DW));
    check("sclk_rises",  32'(rises), 32'(DW));
    check("sclk_idle",   32'(if_m.sclk), 32'(pol));
    check("ssn_idle",    32'(if_m.ssn), 32'(all_hi));
    @(posedge clk); #1;
    check("no_requeue",  32'(if_m.busy), 32'(0));
  endtask

  logic [1:0] modes [3];
  logic [1:0] m;

  initial begin
    load = 1'b0; unload = 1'b0; datain = '0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; ss_sel = '0; use_lb = 1'b1; ext_miso = 1'b0;
    modes[0] = MODE1; modes[1] = MODE2; modes[2] = MODE3;

    apply_reset();

    // Mode 0, fastest SCLK.
    m = MODE0;
    xfer(8'hA5, m[1], m[0], 8'd0, 2'd0, 1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b0);
    do_unload();

    // Remaining modes with a divided clock.
    for (int i = 0; i < 3; i++) begin
      m = modes[i];
      xfer(8'h3C, m[1], m[0], 8'd3, 2'd1, 1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b0);
      do_unload();
    end

    // Second word without unload sets overrun.
    xfer(8'h11, 1'b0, 1'b0, 8'd1, 2'd0, 1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b0);
    xfer(8'h22, 1'b0, 1'b0, 8'd1, 2'd0, 1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b0);
    do_unload();

    // Load pulsed while busy is ignored.
    xfer(8'h5A, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1, 8'h00, -1, 1'b1, 1'b0, 1'b0);
    do_unload();

    // Reset during SHIFT, then a clean transfer.
    xfer(8'hC3, 1'b1, 1'b0, 8'd2, 2'd0, 1'b1, 8'h00, 5, 1'b0, 1'b0, 1'b0);
    xfer(8'h96, 1'b1, 1'b0, 8'd0, 2'd1, 1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b0);
    do_unload();

    // External serial pattern 1,0,0,... with an out-of-range select.
    xfer(8'hFF, 1'b0, 1'b0, 8'd1, 2'd3, 1'b0, 8'h80, -1, 1'b0, 1'b0, 1'b0);

    // Unload coinciding with completion while the previous word is unread.
    xfer(8'h4E, 1'b0, 1'b1, 8'd0, 2'd2, 1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b1);
    do_unload();

    // Randomised transfers against the reference model.
    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] rd, rp;
      logic [1:0]    rm, rs;
      logic [DV-1:0] rdiv;
      logic          rlb, rus;
      rd   = DW'($urandom);
      rp   = DW'($urandom);
      rm   = 2'($urandom_range(0, 3));
      rs   = 2'($urandom_range(0, 3));
      rdiv = DV'($urandom_range(0, 4));
      rlb  = 1'($urandom_range(0, 1));
      rus  = 1'($urandom_range(0, 1));
      xfer(rd, rm[1], rm[0], rdiv, rs, rlb, rp, -1, 1'b0, rus, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
